alu_operand_collector: RTL and testbench
========================================

// Module: alu_operand_collector
// PURPOSE
//  Input staging stage that sits directly upstream of the ALU core.
//  - Operands arrive on opa/opb, possibly in different cycles, as flagged by inp_valid.
//  - Holds the command and any partial operands, and waits up to TIMEOUT ce-cycles for the missing operand.
//  - Then presents one complete, registered operation to the ALU over a valid/ready handshake.
//  - An operation that times out is still issued, with out_err=1.
// PARAMETERS
//  WIDTH      8   operand width in bits
//  CMD_WIDTH  4   command field width
//  TIMEOUT    16  ce-cycles spent in WAIT before a partial operation is force-issued (>=2)
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          reset, asynchronous, active-high
//  ce         in   1          clock enable; when 0, inputs are ignored and the FSM/counter are frozen
//  mode       in   1          1 = arithmetic, 0 = logical
//  cin        in   1          carry in, forwarded with the operation
//  cmd        in   CMD_WIDTH  ALU command
//  inp_valid  in   2          bit0 = opa valid, bit1 = opb valid
//  opa        in   WIDTH      operand A
//  opb        in   WIDTH      operand B
//  in_ready   out  1          1 in IDLE and WAIT; 0 in ISSUE
//  out_valid  out  1          registered operation available to the ALU
//  out_ready  in   1          ALU accepts the operation
//  out_opa    out  WIDTH      held operand A
//  out_opb    out  WIDTH      held operand B
//  out_cmd    out  CMD_WIDTH  held command
//  out_mode   out  1          held mode
//  out_cin    out  1          held carry in
//  out_err    out  1          1 = operation issued on timeout with an operand missing
// BEHAVIOUR
//  Reset: all outputs 0 except in_ready=1. State=IDLE, counter=0, held regs=0.
//   rst asserted mid-operation discards the pending operation immediately.
//  Required-operand decode, combinational on cmd/mode (need[1:0] = {B,A}):
//   mode=1: cmd 4,5 -> 01; cmd 6,7 -> 10; all others -> 11.
//   mode=0: cmd 6,8,9 -> 01; cmd 7,10,11 -> 10; all others -> 11.
//  Inputs are sampled only when ce=1 and state != ISSUE.
//  IDLE:
//   - inp_valid=00: no action.
//   - Otherwise latch cmd/mode/cin/need and each operand whose valid bit is set (got |= inp_valid).
//   - If got covers need: -> ISSUE. Otherwise -> WAIT with cnt=0.
//  WAIT:
//   - cmd/mode/cin inputs are ignored; the latched values hold.
//   - Any operand presented is latched and overwrites a previously held value.
//   - got covers need -> ISSUE, out_err=0.
//   - Else if cnt==TIMEOUT-1 -> ISSUE, out_err=1. The missing operand keeps its held or zero value.
//   - Else cnt++.
//   - Completion on the timeout cycle wins: out_err=0.
//  ISSUE:
//   - out_valid=1 and all out_* are stable until a cycle with out_ready=1.
//   - On that cycle go to IDLE and clear out_valid, out_err, got and cnt.
//   - No new operation is accepted in this state.
//  Latency: a complete operation accepted in IDLE gives out_valid on the next rising edge (1 cycle).
//  ce=0 in WAIT: cnt does not advance, so the timeout measures ce-cycles only.
//  ce=0 in ISSUE: has no effect; the handshake still completes on out_ready.
//  Unneeded operands that arrive are still latched and forwarded; they do not affect the decision.
// TESTING
//  1. mode=1,cmd=0,inp_valid=11,opa=8'h12,opb=8'h34,out_ready=1
//     -> next cycle: out_valid=1, out_opa=12, out_opb=34, out_err=0; IDLE on the following cycle.
//  2. mode=1,cmd=0: cycle0 inp_valid=01,opa=8'hA5; cycle3 inp_valid=10,opb=8'h5A
//     -> out_valid on cycle4, out_opa=A5, out_opb=5A, out_err=0.
//  3. mode=1,cmd=0,inp_valid=01, then 00 for all cycles
//     -> out_valid=1 with out_err=1 exactly after TIMEOUT(16) WAIT cycles; out_opb=0.
//  4. mode=1,cmd=4 (INC_A),inp_valid=01,opa=8'hFF
//     -> immediate ISSUE (no WAIT), out_err=0.
//     Repeat with mode=0,cmd=7, inp_valid=10 -> immediate ISSUE.
//  5. Partial in WAIT with ce=0 for 20 cycles, then opb supplied
//     -> no timeout, out_err=0. Separately: out_ready=0 for 5 cycles in ISSUE
//     -> outputs stable, in_ready=0, new inputs ignored.
//  6. rst pulsed while in WAIT (cnt=9) and while in ISSUE
//     -> out_valid=0, out_*=0, in_ready=1 asynchronously; next operation behaves as from reset.

Source files
------------

// File: rtl/alu_operand_collector.sv
// Operand staging in front of the ALU: gathers cmd plus up to two operands, waits a bounded
// number of ce-cycles for a missing operand, then offers one registered operation on valid/ready.
module alu_operand_collector #(
  parameter int WIDTH     = 8,
  parameter int CMD_WIDTH = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 mode,
  input  logic                 cin,
  input  logic [CMD_WIDTH-1:0] cmd,
  input  logic [1:0]           inp_valid,
  input  logic [WIDTH-1:0]     opa,
  input  logic [WIDTH-1:0]     opb,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_opa,
  output logic [WIDTH-1:0]     out_opb,
  output logic [CMD_WIDTH-1:0] out_cmd,
  output logic                 out_mode,
  output logic                 out_cin,
  output logic                 out_err
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ISSUE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           got_q, got_d;
  logic [1:0]           need_q, need_d;
  logic [WIDTH-1:0]     opa_q, opa_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [CMD_WIDTH-1:0] cmd_q, cmd_d;
  logic                 mode_q, mode_d;
  logic                 cin_q, cin_d;
  logic                 err_q, err_d;
  logic [1:0]           need_in;
  logic [1:0]           got_n;

  // need = {B, A}: which operands the command actually consumes
  function automatic logic [1:0] need_of(input logic [CMD_WIDTH-1:0] c, input logic m);
    need_of = 2'b11;
    if (m) begin
      if (c == CMD_WIDTH'(4) || c == CMD_WIDTH'(5))      need_of = 2'b01;
      else if (c == CMD_WIDTH'(6) || c == CMD_WIDTH'(7)) need_of = 2'b10;
    end else begin
      if (c == CMD_WIDTH'(6) || c == CMD_WIDTH'(8) || c == CMD_WIDTH'(9))         need_of = 2'b01;
      else if (c == CMD_WIDTH'(7) || c == CMD_WIDTH'(10) || c == CMD_WIDTH'(11)) need_of = 2'b10;
    end
  endfunction

  assign need_in = need_of(cmd, mode);
  assign got_n   = got_q | inp_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    got_d   = got_q;
    need_d  = need_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    cmd_d   = cmd_q;
    mode_d  = mode_q;
    cin_d   = cin_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (ce && inp_valid != 2'b00) begin
          cmd_d  = cmd;
          mode_d = mode;
          cin_d  = cin;
          need_d = need_in;
          got_d  = inp_valid;
          cnt_d  = '0;
          err_d  = 1'b0;
          if (inp_valid[0]) opa_d = opa;
          if (inp_valid[1]) opb_d = opb;
          state_d = ((inp_valid & need_in) == need_in) ? ISSUE : WAIT;
        end
      end
      WAIT: begin
        if (ce) begin
          if (inp_valid[0]) opa_d = opa;
          if (inp_valid[1]) opb_d = opb;
          got_d = got_n;
          // completion takes priority over a timeout landing on the same cycle
          if ((got_n & need_q) == need_q) begin
            state_d = ISSUE;
            err_d   = 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ISSUE;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ISSUE: begin
        if (out_ready) begin
          state_d = IDLE;
          err_d   = 1'b0;
          got_d   = 2'b00;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      got_q   <= 2'b00;
      need_q  <= 2'b00;
      opa_q   <= '0;
      opb_q   <= '0;
      cmd_q   <= '0;
      mode_q  <= 1'b0;
      cin_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      got_q   <= got_d;
      need_q  <= need_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      cmd_q   <= cmd_d;
      mode_q  <= mode_d;
      cin_q   <= cin_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = (state_q == ISSUE);
  assign in_ready  = (state_q != ISSUE);
  assign out_opa   = opa_q;
  assign out_opb   = opb_q;
  assign out_cmd   = cmd_q;
  assign out_mode  = mode_q;
  assign out_cin   = cin_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_alu_operand_collector.sv
// Randomized and directed checks of alu_operand_collector against a transaction-level model.
module tb_alu_operand_collector;

  localparam int WIDTH = 8;
  localparam int CMD_WIDTH = 4;
  localparam int TIMEOUT = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 ce = 1'b0, mode = 1'b0, cin = 1'b0, out_ready = 1'b0;
  logic [CMD_WIDTH-1:0] cmd = '0;
  logic [1:0]           inp_valid = 2'b00;
  logic [WIDTH-1:0]     opa = '0, opb = '0;
  logic                 in_ready, out_valid, out_mode, out_cin, out_err;
  logic [WIDTH-1:0]     out_opa, out_opb;
  logic [CMD_WIDTH-1:0] out_cmd;

  alu_operand_collector #(.WIDTH(WIDTH), .CMD_WIDTH(CMD_WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ce(ce), .mode(mode), .cin(cin), .cmd(cmd),
    .inp_valid(inp_valid), .opa(opa), .opb(opb), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_opa(out_opa), .out_opb(out_opb),
    .out_cmd(out_cmd), .out_mode(out_mode), .out_cin(out_cin), .out_err(out_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Transaction-level model: one pending operation, how many ce-cycles it has waited,
  // which operands it has, and whether it is being offered to the ALU.
  bit                   m_pend, m_issued, m_err, m_mode, m_cin;
  bit [1:0]             m_have, m_need;
  int                   m_waited;
  bit [WIDTH-1:0]       m_opa, m_opb;
  bit [CMD_WIDTH-1:0]   m_cmd;

  function automatic bit [1:0] need_rule(input bit [CMD_WIDTH-1:0] c, input bit m);
    int ci;
    ci = int'(c);
    if (m) begin
      if (ci inside {4, 5}) return 2'b01;
      if (ci inside {6, 7}) return 2'b10;
    end else begin
      if (ci inside {6, 8, 9})   return 2'b01;
      if (ci inside {7, 10, 11}) return 2'b10;
    end
    return 2'b11;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_issued = 0; m_err = 0; m_mode = 0; m_cin = 0;
    m_have = 0; m_need = 0; m_waited = 0; m_opa = 0; m_opb = 0; m_cmd = 0;
  endtask

  task automatic model_step();
    bit first;
    if (m_issued) begin
      if (out_ready) begin m_issued = 0; m_err = 0; m_pend = 0; end
      return;
    end
    if (!ce) return;
    first = !m_pend;
    if (first) begin
      if (inp_valid == 2'b00) return;
      m_pend = 1; m_cmd = cmd; m_mode = mode; m_cin = cin;
      m_need = need_rule(cmd, mode); m_have = 2'b00; m_waited = 0;
    end
    if (inp_valid[0]) m_opa = opa;
    if (inp_valid[1]) m_opb = opb;
    m_have = m_have | inp_valid;
    if ((m_have & m_need) == m_need) begin
      m_issued = 1; m_err = 0;
    end else if (!first) begin
      m_waited++;
      if (m_waited == TIMEOUT) begin m_issued = 1; m_err = 1; end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("out_valid", 32'(out_valid), 32'(m_issued));
    chk("in_ready",  32'(in_ready),  32'(!m_issued));
    chk("out_err",   32'(out_err),   32'(m_err));
    chk("out_opa",   32'(out_opa),   32'(m_opa));
    chk("out_opb",   32'(out_opb),   32'(m_opb));
    chk("out_cmd",   32'(out_cmd),   32'(m_cmd));
    chk("out_mode",  32'(out_mode),  32'(m_mode));
    chk("out_cin",   32'(out_cin),   32'(m_cin));
  endtask

  // Called at a falling edge: drive inputs, let one rising edge pass, then compare.
  task automatic cycle(input bit c_ce, input bit c_mode, input bit [3:0] c_cmd,
                       input bit [1:0] c_v, input bit [7:0] c_a, input bit [7:0] c_b,
                       input bit c_rdy);
    ce = c_ce; mode = c_mode; cmd = c_cmd; inp_valid = c_v; opa = c_a; opb = c_b;
    out_ready = c_rdy; cin = c_cmd[0];
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    compare_all();
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    compare_all();
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;

    // Complete operation issues after one edge, drains on ready
    cycle(1, 1, 0, 2'b11, 8'h12, 8'h34, 1);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_opa", 32'(out_opa), 32'h12);
    chk("t1_opb", 32'(out_opb), 32'h34);
    chk("t1_err", 32'(out_err), 32'd0);
    cycle(1, 1, 0, 2'b00, 8'h00, 8'h00, 1);
    chk("t1_idle", 32'(out_valid), 32'd0);

    // Operands three cycles apart
    cycle(1, 1, 0, 2'b01, 8'hA5, 8'h00, 1);
    cycle(1, 1, 0, 2'b00, 8'h00, 8'h00, 1);
    cycle(1, 1, 0, 2'b00, 8'h00, 8'h00, 1);
    chk("t2_not_yet", 32'(out_valid), 32'd0);
    cycle(1, 1, 0, 2'b10, 8'h00, 8'h5A, 1);
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_opa", 32'(out_opa), 32'hA5);
    chk("t2_opb", 32'(out_opb), 32'h5A);
    chk("t2_err", 32'(out_err), 32'd0);
    cycle(1, 1, 0, 2'b00, 8'h00, 8'h00, 1);

    // Timeout after exactly TIMEOUT wait cycles
    rst_pulse();
    cycle(1, 1, 0, 2'b01, 8'h33, 8'h00, 1);
    for (int i = 0; i < TIMEOUT - 1; i++) cycle(1, 1, 0, 2'b00, 8'h00, 8'h00, 1);
    chk("t3_before_timeout", 32'(out_valid), 32'd0);
    cycle(1, 1, 0, 2'b00, 8'h00, 8'h00, 1);
    chk("t3_valid", 32'(out_valid), 32'd1);
    chk("t3_err", 32'(out_err), 32'd1);
    chk("t3_opb", 32'(out_opb), 32'd0);
    cycle(1, 1, 0, 2'b00, 8'h00, 8'h00, 1);

    // Single-operand commands issue immediately
    cycle(1, 1, 4, 2'b01, 8'hFF, 8'h00, 1);
    chk("t4a_valid", 32'(out_valid), 32'd1);
    chk("t4a_err", 32'(out_err), 32'd0);
    cycle(1, 1, 0, 2'b00, 8'h00, 8'h00, 1);
    cycle(1, 0, 7, 2'b10, 8'h00, 8'h77, 1);
    chk("t4b_valid", 32'(out_valid), 32'd1);
    cycle(1, 1, 0, 2'b00, 8'h00, 8'h00, 1);

    // ce=0 freezes the wait counter; then stall in ISSUE
    cycle(1, 1, 0, 2'b01, 8'h11, 8'h00, 0);
    for (int i = 0; i < 20; i++) cycle(0, 1, 0, 2'b11, 8'hEE, 8'hEE, 0);
    chk("t5_frozen", 32'(out_valid), 32'd0);
    cycle(1, 1, 0, 2'b10, 8'h00, 8'hC3, 0);
    chk("t5_valid", 32'(out_valid), 32'd1);
    chk("t5_err", 32'(out_err), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 9, 2'b11, 8'h99, 8'h99, 0);
      chk("t5_stall_opb", 32'(out_opb), 32'hC3);
      chk("t5_stall_rdy", 32'(in_ready), 32'd0);
    end
    cycle(1, 1, 0, 2'b00, 8'h00, 8'h00, 1);

    // Reset in WAIT at cnt=9 and in ISSUE
    cycle(1, 1, 0, 2'b01, 8'h44, 8'h00, 1);
    for (int i = 0; i < 9; i++) cycle(1, 1, 0, 2'b00, 8'h00, 8'h00, 1);
    rst_pulse();
    chk("t6_wait_opa", 32'(out_opa), 32'd0);
    cycle(1, 1, 0, 2'b11, 8'h55, 8'h66, 0);
    rst_pulse();
    chk("t6_issue_valid", 32'(out_valid), 32'd0);
    cycle(1, 1, 0, 2'b11, 8'h12, 8'h34, 1);
    chk("t6_after_valid", 32'(out_valid), 32'd1);
    chk("t6_after_opa", 32'(out_opa), 32'h12);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) rst_pulse();
      else cycle($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom),
                 ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom),
                 8'($urandom), 8'($urandom), $urandom_range(0, 4) < 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
